// File: rtl/alu_arbiter_seq_pkg.sv
// Shared ALU op codes, P-register bit positions and arbiter FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_arbiter_seq_pkg;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_INC = 4'd6;
    localparam logic [3:0] OP_DEC = 4'd7;
    localparam logic [3:0] OP_ASL = 4'd8;
    localparam logic [3:0] OP_LSR = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;
    localparam logic [3:0] OP_ROL = 4'd11;

    localparam int PSR_N = 7;
    localparam int PSR_V = 6;
    localparam int PSR_B = 4;
    localparam int PSR_D = 3;
    localparam int PSR_I = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_C = 0;

    // Bits 5 and 4 of P never come from the ALU, whatever the mask says.
    localparam logic [7:0] PSR_KEEP = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic [7:0] merge_psr(input logic [7:0] psr,
                                             input logic [7:0] flags,
                                             input logic [7:0] mask);
        logic [7:0] m;
        m = mask & ~PSR_KEEP;
        return (psr & ~m) | (flags & m);
    endfunction

endpackage

// File: rtl/alu_arbiter_seq_rr_arbiter.sv
// Round-robin picker: first set request bit searched upward from the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_id,
    output logic            o_any
);

    int w_idx;

    // Walk from the farthest candidate back to the pointer so the nearest one wins.
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_id           = IDW'(w_idx);
                o_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Shares one registered ALU between NREQ requesters; returns merged flags with a tag.
// Latency: accept -> resp_valid in ALU_LATENCY+2 cycles; at least 4 cycles per op.
// Backpressure: resp_* held until resp_ready; no grant is issued outside IDLE.
module alu_arbiter_seq
    import alu_arbiter_seq_pkg::*;
#(
    parameter  int NREQ        = 2,
    parameter  int ALU_LATENCY = 1,
    localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_op,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [8*NREQ-1:0] req_psr,
    input  logic [8*NREQ-1:0] req_mask,
    output logic [3:0]        alu_op,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic              alu_carry,
    output logic              alu_decimal,
    input  logic [7:0]        alu_result,
    input  logic [7:0]        alu_psr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [7:0]        resp_result,
    output logic [7:0]        resp_psr,
    output logic              busy
);

    state_t          r_state, w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr, r_id;
    logic [3:0]      r_op;
    logic [7:0]      r_a, r_b, r_psr, r_mask;
    logic [1:0]      r_cnt;
    logic [3:0]      r_alu_op;
    logic [7:0]      r_alu_a, r_alu_b;
    logic            r_alu_c, r_alu_d;
    logic            r_resp_valid;
    logic [IDW-1:0]  r_resp_id;
    logic [7:0]      r_resp_result, r_resp_psr;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_id;
    logic            w_any, w_accept, w_capture, w_release;
    logic [3:0]      w_sel_op;
    logic [7:0]      w_sel_a, w_sel_b, w_sel_psr, w_sel_mask, w_flags;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_id    (w_id),
        .o_any   (w_any)
    );

    assign w_sel_op   = req_op  [4*int'(w_id) +: 4];
    assign w_sel_a    = req_a   [8*int'(w_id) +: 8];
    assign w_sel_b    = req_b   [8*int'(w_id) +: 8];
    assign w_sel_psr  = req_psr [8*int'(w_id) +: 8];
    assign w_sel_mask = req_mask[8*int'(w_id) +: 8];

    assign req_ready   = (r_state == ST_IDLE && !rst) ? w_grant : '0;
    assign busy        = (r_state != ST_IDLE);
    assign alu_op      = r_alu_op;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_carry   = r_alu_c;
    assign alu_decimal = r_alu_d;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_psr    = r_resp_psr;

    // CMP carry from the ALU is not trusted; recompute it as unsigned a >= b.
    always_comb begin
        w_flags = alu_psr;
        if (r_op == OP_CMP) begin
            w_flags[PSR_C] = (r_a >= r_b);
        end
    end

    // Next-state logic and the one-cycle strobes that drive the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch, ALU operand bus, latency counter, response register and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_id          <= '0;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_psr         <= '0;
            r_mask        <= '0;
            r_cnt         <= '0;
            r_alu_op      <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_c       <= 1'b0;
            r_alu_d       <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_psr    <= '0;
        end else begin
            if (w_accept) begin
                r_id     <= w_id;
                r_op     <= w_sel_op;
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_psr    <= w_sel_psr;
                r_mask   <= w_sel_mask;
                r_alu_op <= w_sel_op;
                r_alu_a  <= w_sel_a;
                r_alu_b  <= w_sel_b;
                r_alu_c  <= w_sel_psr[PSR_C];
                r_alu_d  <= w_sel_psr[PSR_D];
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= 2'(ALU_LATENCY - 1);
            end else if (r_state == ST_WAIT && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_capture) begin
                r_resp_valid  <= 1'b1;
                r_resp_id     <= r_id;
                r_resp_result <= alu_result;
                r_resp_psr    <= merge_psr(r_psr, w_flags, r_mask);
            end
            if (w_release) begin
                r_resp_valid <= 1'b0;
                r_rr_ptr     <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: one instance per ALU latency (1 and 3), each with a behavioural ALU.
// Latency: checks accept -> response timing against ALU_LATENCY+2.
// Backpressure: stalls resp_ready and checks hold, no grant, and release timing.
module tb_alu_arbiter_seq;
    import alu_arbiter_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  vld_raw;
    logic        sel;
    logic [7:0]  req_op;
    logic [15:0] req_a, req_b, req_psr, req_mask;
    logic        resp_ready;

    logic [1:0]  v0, v1, d0_rdy, d1_rdy;
    logic [3:0]  d0_aop, d1_aop;
    logic [7:0]  d0_aa, d0_ab, d1_aa, d1_ab, d0_ares, d0_apsr, d1_ares, d1_apsr;
    logic        d0_ac, d0_ad, d1_ac, d1_ad, d0_rv, d1_rv, d0_busy, d1_busy;
    logic        d0_rid, d1_rid;
    logic [7:0]  d0_rres, d0_rpsr, d1_rres, d1_rpsr;

    logic [1:0]  o_rdy;
    logic        o_rv, o_rid, o_busy;
    logic [7:0]  o_res, o_psr;
    logic [3:0]  o_aop;

    int n_chk = 0;
    int n_err = 0;
    int rr[2];

    always #5 clk = ~clk;

    assign v0     = sel ? 2'b00 : vld_raw;
    assign v1     = sel ? vld_raw : 2'b00;
    assign o_rdy  = sel ? d1_rdy  : d0_rdy;
    assign o_rv   = sel ? d1_rv   : d0_rv;
    assign o_rid  = sel ? d1_rid  : d0_rid;
    assign o_busy = sel ? d1_busy : d0_busy;
    assign o_res  = sel ? d1_rres : d0_rres;
    assign o_psr  = sel ? d1_rpsr : d0_rpsr;
    assign o_aop  = sel ? d1_aop  : d0_aop;

    alu_arbiter_seq #(.NREQ(2), .ALU_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(d0_rdy),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_psr(req_psr), .req_mask(req_mask),
        .alu_op(d0_aop), .alu_a(d0_aa), .alu_b(d0_ab), .alu_carry(d0_ac), .alu_decimal(d0_ad),
        .alu_result(d0_ares), .alu_psr(d0_apsr),
        .resp_valid(d0_rv), .resp_ready(resp_ready), .resp_id(d0_rid),
        .resp_result(d0_rres), .resp_psr(d0_rpsr), .busy(d0_busy)
    );

    alu_arbiter_seq #(.NREQ(2), .ALU_LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(d1_rdy),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_psr(req_psr), .req_mask(req_mask),
        .alu_op(d1_aop), .alu_a(d1_aa), .alu_b(d1_ab), .alu_carry(d1_ac), .alu_decimal(d1_ad),
        .alu_result(d1_ares), .alu_psr(d1_apsr),
        .resp_valid(d1_rv), .resp_ready(resp_ready), .resp_id(d1_rid),
        .resp_result(d1_rres), .resp_psr(d1_rpsr), .busy(d1_busy)
    );

    // Behavioural ALU: {PSRout, Result}. Its CMP carry is deliberately a borrow (a < b).
    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c, input logic d);
        logic [8:0] s;
        logic [7:0] r;
        logic co, v;
        s = '0; r = a; co = c; v = 1'b0;
        case (op)
            OP_ADC: begin s = {1'b0, a} + {1'b0, b} + 9'(c); r = s[7:0]; co = s[8];
                          v = ~(a[7] ^ b[7]) & (a[7] ^ r[7]); end
            OP_SBC: begin s = {1'b0, a} + {1'b0, ~b} + 9'(c); r = s[7:0]; co = s[8];
                          v = (a[7] ^ b[7]) & (a[7] ^ r[7]); end
            OP_AND: r = a & b;
            OP_ORA: r = a | b;
            OP_EOR: r = a ^ b;
            OP_CMP: begin r = a - b; co = (a < b); end
            OP_INC: r = a + 8'd1;
            OP_DEC: r = a - 8'd1;
            OP_ASL: begin r = {a[6:0], 1'b0}; co = a[7]; end
            OP_LSR: begin r = {1'b0, a[7:1]}; co = a[0]; end
            OP_ROR: begin r = {c, a[7:1]}; co = a[0]; end
            OP_ROL: begin r = {a[6:0], c}; co = a[7]; end
            default: r = a;
        endcase
        return {r[7], v, 2'b11, d, 1'b0, (r == 8'h00), co, r};
    endfunction

    // Expected {resp_psr, resp_result} for one request, from the merge and CMP rules.
    function automatic logic [15:0] ref_resp(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] psr,
                                             input logic [7:0] mask);
        logic [15:0] f;
        logic [7:0]  flags, m;
        f     = alu_f(op, a, b, psr[0], psr[3]);
        flags = f[15:8];
        if (op == OP_CMP) flags[0] = (a >= b);
        m = mask & 8'hCF;
        return {(psr & ~m) | (flags & m), f[7:0]};
    endfunction

    function automatic int pick(input logic [1:0] vld, input int ptr);
        for (int k = 0; k < 2; k++) begin
            if (vld[(ptr + k) % 2]) return (ptr + k) % 2;
        end
        return -1;
    endfunction

    // Registered ALU pipelines, one per instance latency.
    logic [15:0] p0;
    logic [15:0] p1 [3];
    always @(posedge clk) begin
        p0    <= alu_f(d0_aop, d0_aa, d0_ab, d0_ac, d0_ad);
        p1[0] <= alu_f(d1_aop, d1_aa, d1_ab, d1_ac, d1_ad);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign d0_ares = p0[7:0];
    assign d0_apsr = p0[15:8];
    assign d1_ares = p1[2][7:0];
    assign d1_apsr = p1[2][15:8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] p, input logic [7:0] m);
        req_op[4*i +: 4] = op;
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_psr[8*i +: 8] = p;
        req_mask[8*i +: 8] = m;
    endtask

    task automatic scramble();
        req_op   = 8'($urandom);
        req_a    = 16'($urandom);
        req_b    = 16'($urandom);
        req_psr  = 16'($urandom);
        req_mask = 16'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld_raw = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rr[0] = 0;
        rr[1] = 0;
    endtask

    // One full transaction on the selected instance; starts and ends away from the clock edge.
    task automatic do_txn(input logic [1:0] vld, input bit keep, input int bp,
                          output int got_id, output logic [7:0] got_res, output logic [7:0] got_psr);
        int lat, eid, n;
        logic [15:0] exp;
        logic [3:0]  eop;
        lat = sel ? 3 : 1;
        vld_raw = vld;
        resp_ready = (bp == 0);
        #1;
        eid = pick(vld, rr[int'(sel)]);
        check("grant", 32'(o_rdy), 32'(1) << eid);
        check("idle_busy", 32'(o_busy), 32'd0);
        eop = req_op[4*eid +: 4];
        exp = ref_resp(eop, req_a[8*eid +: 8], req_b[8*eid +: 8],
                       req_psr[8*eid +: 8], req_mask[8*eid +: 8]);
        @(posedge clk);
        #1;
        if (!keep) vld_raw = 2'b00;
        scramble();
        n = 0;
        while (n < 12) begin
            n++;
            @(negedge clk);
            if (n == 1) check("alu_op", 32'(o_aop), 32'(eop));
            if (o_rv) break;
            check("wait_ready", 32'(o_rdy), 32'd0);
            @(posedge clk);
            #1;
        end
        check("latency", 32'(n), 32'(lat + 2));
        got_id  = int'(o_rid);
        got_res = o_res;
        got_psr = o_psr;
        check("resp_id", 32'(o_rid), 32'(eid));
        check("resp_result", 32'(o_res), 32'(exp[7:0]));
        check("resp_psr", 32'(o_psr), 32'(exp[15:8]));
        for (int k = 0; k < bp; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("hold_valid", 32'(o_rv), 32'd1);
            check("hold_result", 32'(o_res), 32'(exp[7:0]));
            check("hold_psr", 32'(o_psr), 32'(exp[15:8]));
            check("hold_ready", 32'(o_rdy), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        rr[int'(sel)] = (eid + 1) % 2;
        check("release_busy", 32'(o_busy), 32'd0);
        check("release_valid", 32'(o_rv), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int id;
        logic [7:0] res, psr;
        sel = 1'b0;
        resp_ready = 1'b0;
        vld_raw = 2'b00;
        req_op = '0; req_a = '0; req_b = '0; req_psr = '0; req_mask = '0;
        do_reset();

        // Reset state of both instances.
        check("rst_rdy0", 32'(d0_rdy), 32'd0);
        check("rst_rv0", 32'(d0_rv), 32'd0);
        check("rst_busy0", 32'(d0_busy), 32'd0);
        check("rst_res0", 32'({d0_rres, d0_rpsr}), 32'd0);
        check("rst_alu0", 32'({d0_aop, d0_aa, d0_ab, d0_ac, d0_ad}), 32'd0);
        check("rst_rv1", 32'(d1_rv), 32'd0);
        check("rst_busy1", 32'(d1_busy), 32'd0);
        check("rst_id1", 32'(d1_rid), 32'd0);

        // Single ADC.
        set_req(0, OP_ADC, 8'h50, 8'h50, 8'h00, 8'hC3);
        do_txn(2'b01, 1'b0, 0, id, res, psr);
        check("s1_result", 32'(res), 32'hA0);
        check("s1_psr", 32'(psr), 32'hC0);
        check("s1_id", 32'(id), 32'd0);

        // CMP carry fix, both orderings.
        set_req(1, OP_CMP, 8'h40, 8'h30, 8'h00, 8'h83);
        do_txn(2'b10, 1'b0, 0, id, res, psr);
        check("s2_result", 32'(res), 32'h10);
        check("s2_c_set", 32'(psr[0]), 32'd1);
        set_req(0, OP_CMP, 8'h30, 8'h40, 8'h00, 8'h83);
        do_txn(2'b01, 1'b0, 0, id, res, psr);
        check("s2_c_clr", 32'(psr[0]), 32'd0);
        check("s2_n_set", 32'(psr[7]), 32'd1);

        // Mask preserve with INC.
        set_req(1, OP_INC, 8'hFF, 8'h00, 8'h0D, 8'h82);
        do_txn(2'b10, 1'b0, 0, id, res, psr);
        check("s5_psr", 32'(psr), 32'h0F);

        // Round-robin with both requesters continuously valid.
        scramble();
        for (int i = 0; i < 4; i++) begin
            do_txn(2'b11, 1'b1, 0, id, res, psr);
            check("s3_rr_seq", 32'(id), 32'(i % 2));
        end

        // Backpressure with both still requesting.
        do_txn(2'b11, 1'b1, 5, id, res, psr);
        vld_raw = 2'b00;

        // Reset while in WAIT discards the op and clears the pointer.
        scramble();
        vld_raw = 2'b11;
        #1;
        check("s6_grant_pre", 32'(o_rdy), 32'b10);
        @(posedge clk);
        #1;
        vld_raw = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rr[0] = 0;
        rr[1] = 0;
        check("s6_no_resp", 32'(o_rv), 32'd0);
        check("s6_busy", 32'(o_busy), 32'd0);
        vld_raw = 2'b11;
        #1;
        check("s6_grant_post", 32'(o_rdy), 32'b01);
        vld_raw = 2'b00;
        #1;

        // Latency-3 instance.
        sel = 1'b1;
        set_req(0, OP_ADC, 8'h50, 8'h50, 8'h00, 8'hC3);
        do_txn(2'b01, 1'b0, 0, id, res, psr);
        check("s6_l3_psr", 32'(psr), 32'hC0);

        // Randomized traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 30; i++) begin
                scramble();
                do_txn(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), id, res, psr);
            end
            vld_raw = 2'b00;
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
